mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter RD_WAIT, default 0: extra read-hold cycles (0..7) before RAM_Q is sampled.
REQ-002 SHALL have parameter WP_LIMIT, default 12'h100: first writable address; used only with MEMCTL_WP_EN.
REQ-003 SHALL have port CLK  input  1  sole clock; rising-edge active.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port REQ_VALID  input  1  requester has a transaction.
REQ-006 SHALL have port REQ_READY  output  1  controller accepts a transaction this cycle.
REQ-007 SHALL have port REQ_WE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port REQ_ADDR  input  12  word address.
REQ-009 SHALL have port REQ_DATA  input  16  write data.
REQ-010 SHALL have port RSP_VALID  output  1  response available.
REQ-011 SHALL have port RSP_READY  input  1  requester takes the response.
REQ-012 SHALL have port RSP_DATA  output  16  read data, or echoed write data.
REQ-013 SHALL have port RSP_ERR  output  1  write was refused (protected region).
REQ-014 SHALL have ports RAM_ADDR output 12, RAM_D output 16, RAM_W output 1, RAM_R output 1, RAM_E output 1: drive the 4K-word RAM array.
REQ-015 SHALL have port RAM_Q  input  16  RAM read output; combinational, valid only while RAM_R and RAM_E are high.

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, RESP.
REQ-017 IDLE: REQ_READY=1; a handshake (REQ_VALID and REQ_READY at a rising edge) SHALL latch REQ_WE, REQ_ADDR and REQ_DATA, then go to WRITE or READ.
REQ-018 REQ_READY SHALL be 0 in every state except IDLE; requests are never queued.
REQ-019 WRITE: exactly one cycle with RAM_E=1, RAM_W=1, RAM_R=0, RAM_ADDR and RAM_D from the latched values; the RAM commits at the edge that ends the cycle; next state RESP with RSP_DATA=latched data and RSP_ERR=0.
REQ-020 READ: RAM_E=1, RAM_R=1, RAM_W=0 for 1+RD_WAIT cycles, counted by a 3-bit counter; RAM_Q SHALL be registered into RSP_DATA only at the edge ending the last READ cycle; next state RESP.
REQ-021 RESP: RSP_VALID=1, and RSP_DATA/RSP_ERR SHALL hold stable until RSP_READY is sampled high; then return to IDLE.
REQ-022 RAM_E, RAM_W and RAM_R SHALL decode directly from state registers, glitch-free, and be 0 in IDLE and RESP.
REQ-023 Latency from the handshake edge to RSP_VALID high SHALL be 1 cycle for writes and 1+RD_WAIT cycles for reads.
REQ-024 Minimum spacing between accepted requests SHALL be 3 cycles; a REQ_VALID held high while REQ_READY=0 is ignored.
REQ-025 RSP_READY held high before RESP SHALL have no effect.

Reset
REQ-026 While RST=1: state=IDLE, wait counter=0, REQ_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, all RAM_* outputs=0.
REQ-027 RST asserted mid-transaction SHALL drop RAM_W/RAM_E asynchronously so no partial write commits, and SHALL discard any pending response.
REQ-028 REQ_READY SHALL rise in the first cycle after RST deasserts.

Configuration
REQ-029 With macro MEMCTL_WP_EN defined, a write to an address below WP_LIMIT SHALL keep RAM_W=0 and RAM_E=0 for its WRITE cycle and return RSP_ERR=1 and RSP_DATA=0, with latency unchanged.
REQ-030 Without MEMCTL_WP_EN, all writes SHALL proceed, RSP_ERR SHALL be tied to 0, and WP_LIMIT SHALL be ignored.

Verification
REQ-031 Write 0xBEEF to 0x3A5, then read 0x3A5 (RD_WAIT=0) -> write response after 1 cycle with RSP_DATA=0xBEEF; read response after 1 cycle with RSP_DATA=0xBEEF.
REQ-032 RD_WAIT=3; read 0xFFF preloaded with 0x1234 -> RAM_R high for exactly 4 cycles; RSP_VALID rises on the 4th edge with 0x1234.
REQ-033 Hold RSP_READY=0 for 5 cycles in RESP -> RSP_VALID, RSP_DATA and REQ_READY stay constant; a new REQ_VALID is not accepted until 1 cycle after RSP_READY.
REQ-034 Assert RST midway through a WRITE of 0x5555 to 0x010 (old value 0xAAAA) -> all outputs go to 0 immediately; a later read of 0x010 returns 0xAAAA.
REQ-035 MEMCTL_WP_EN with WP_LIMIT=0x100: write 0x0042 to 0x0FF -> RSP_ERR=1 and RAM_W never high; the same write to 0x100 -> RSP_ERR=0 and a read back returns 0x0042.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Single-outstanding request/response controller in front of a 4K x 16
// single-port RAM with a combinational read output.
// A request is accepted in IDLE. A write spends one cycle in WRITE. A read
// spends 1+RD_WAIT cycles in READ, and RAM_Q is registered on the last of
// those cycles. The response is then held in RESP until the requester takes it.
//
// Parameters
//   RD_WAIT   extra read-hold cycles (0..7) before RAM_Q is sampled
//   WP_LIMIT  first writable word address (only with MEMCTL_WP_EN)
//
// Ports
//   CLK, RST                        clock (rising edge); async active-high reset
//   REQ_VALID/REQ_READY             request handshake
//   REQ_WE, REQ_ADDR, REQ_DATA      request: 1=write, word address, write data
//   RSP_VALID/RSP_READY             response handshake
//   RSP_DATA, RSP_ERR               read data or echoed write data; write refused
//   RAM_ADDR, RAM_D                 RAM address / write data
//   RAM_W, RAM_R, RAM_E             RAM write, read and enable strobes
//   RAM_Q                           RAM read data (valid while RAM_R & RAM_E)
//
// Optional feature
//   MEMCTL_WP_EN  when defined, writes below WP_LIMIT are refused. The RAM is
//                 left untouched, and RSP_ERR=1 with RSP_DATA=0 is returned
//                 after the same latency as a normal write.
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int unsigned RD_WAIT  = 0,
    parameter logic [11:0] WP_LIMIT = 12'h100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [11:0] REQ_ADDR,
    input  logic [15:0] REQ_DATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic [11:0] RAM_ADDR,
    output logic [15:0] RAM_D,
    output logic        RAM_W,
    output logic        RAM_R,
    output logic        RAM_E,
    input  logic [15:0] RAM_Q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Value of the wait counter on the final READ cycle.
    localparam logic [2:0] RD_LAST = RD_WAIT[2:0];

    state_t      state_q,     state_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic [11:0] addr_q,      addr_d;
    logic [15:0] wdata_q,     wdata_d;
    logic [15:0] rsp_data_q,  rsp_data_d;
    logic        rsp_err_q,   rsp_err_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        ram_e_q,     ram_e_d;
    logic        ram_w_q,     ram_w_d;
    logic        ram_r_q,     ram_r_d;

    // wp_req: incoming write targets the protected region.
    // wp_hit: latched write in WRITE targets the protected region.
    logic        wp_req;
    logic        wp_hit;

`ifdef MEMCTL_WP_EN
    assign wp_req  = REQ_ADDR < WP_LIMIT;
    assign wp_hit  = addr_q < WP_LIMIT;
    assign RSP_ERR = rsp_err_q;
`else
    assign wp_req  = 1'b0;
    assign wp_hit  = 1'b0;
    assign RSP_ERR = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{WP_LIMIT, rsp_err_q};
`endif

    // RAM strobes are registered copies of the next-state decode. They are
    // therefore glitch-free, and the async reset clears them immediately, so
    // a write interrupted by reset never commits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = 1'b0;
        ram_e_d     = 1'b0;
        ram_w_d     = 1'b0;
        ram_r_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ_VALID) begin
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_DATA;
                    cnt_d   = 3'd0;
                    if (REQ_WE) begin
                        state_d = S_WRITE;
                        // A refused write still passes through WRITE so that
                        // its latency matches a normal write.
                        ram_e_d = !wp_req;
                        ram_w_d = !wp_req;
                    end else begin
                        state_d = S_READ;
                        ram_e_d = 1'b1;
                        ram_r_d = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = wp_hit ? 16'h0000 : wdata_q;
                rsp_err_d   = wp_hit;
            end

            S_READ: begin
                if (cnt_q == RD_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = RAM_Q;
                    rsp_err_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_q + 3'd1;
                    ram_e_d = 1'b1;
                    ram_r_d = 1'b1;
                end
            end

            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            addr_q      <= 12'h000;
            wdata_q     <= 16'h0000;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            ram_e_q     <= 1'b0;
            ram_w_q     <= 1'b0;
            ram_r_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            ram_e_q     <= ram_e_d;
            ram_w_q     <= ram_w_d;
            ram_r_q     <= ram_r_d;
        end
    end

    // Ready is held low for as long as reset is asserted. It rises as soon
    // as reset is released, because the state is already IDLE.
    assign REQ_READY = (state_q == S_IDLE) && !RST;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_DATA  = rsp_data_q;
    assign RAM_ADDR  = addr_q;
    assign RAM_D     = wdata_q;
    assign RAM_E     = ram_e_q;
    assign RAM_W     = ram_w_q;
    assign RAM_R     = ram_r_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// The bench drives two instances of the controller:
//   dut  (RD_WAIT=0) is covered by a queued scoreboard and a negedge monitor.
//   dut3 (RD_WAIT=3) is used for the long-read timing check.
// Each instance has its own behavioural 4K x 16 RAM with a combinational read.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [11:0] req_addr;
    logic [15:0] req_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_data;
    logic [11:0] ram_addr;
    logic [15:0] ram_d, ram_q;
    logic        ram_w, ram_r, ram_e;

    logic [15:0] mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)              mem[pre_addr] <= pre_data;
        else if (ram_e && ram_w) mem[ram_addr] <= ram_d;
    end
    assign ram_q = (ram_r && ram_e) ? mem[ram_addr] : 16'h0000;

    mem_access_ctrl #(.RD_WAIT(0), .WP_LIMIT(12'h100)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
        .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
        .RSP_ERR(rsp_err),
        .RAM_ADDR(ram_addr), .RAM_D(ram_d), .RAM_W(ram_w), .RAM_R(ram_r),
        .RAM_E(ram_e), .RAM_Q(ram_q)
    );

    // Second instance used for the RD_WAIT=3 read.
    logic        r3_valid, r3_ready, r3_we;
    logic [11:0] r3_addr;
    logic [15:0] r3_data;
    logic        s3_valid, s3_ready, s3_err;
    logic [15:0] s3_data;
    logic [11:0] ram3_addr;
    logic [15:0] ram3_d, ram3_q;
    logic        ram3_w, ram3_r, ram3_e;
    logic [15:0] mem3 [0:4095];
    logic        pre3_we;

    always @(posedge clk) begin
        if (pre3_we)                mem3[pre_addr]  <= pre_data;
        else if (ram3_e && ram3_w)  mem3[ram3_addr] <= ram3_d;
    end
    assign ram3_q = (ram3_r && ram3_e) ? mem3[ram3_addr] : 16'h0000;

    mem_access_ctrl #(.RD_WAIT(3), .WP_LIMIT(12'h100)) dut3 (
        .CLK(clk), .RST(rst),
        .REQ_VALID(r3_valid), .REQ_READY(r3_ready), .REQ_WE(r3_we),
        .REQ_ADDR(r3_addr), .REQ_DATA(r3_data),
        .RSP_VALID(s3_valid), .RSP_READY(s3_ready), .RSP_DATA(s3_data),
        .RSP_ERR(s3_err),
        .RAM_ADDR(ram3_addr), .RAM_D(ram3_d), .RAM_W(ram3_w), .RAM_R(ram3_r),
        .RAM_E(ram3_e), .RAM_Q(ram3_q)
    );

    // ---------------------------------------------------------------- scoring
    typedef struct {
        logic [15:0] d;
        logic        e;
        int          hs;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   last_hs     = 0;
    logic wp_watch    = 1'b0;
    int   w_seen      = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: while a response is presented, compare it with the head of
    // the queue on every cycle, and pop the entry when it is taken.
    initial begin : monitor
        logic mon_prev;
        exp_t cur;
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wp_watch && ram_w) w_seen++;
            if (!rst && rsp_valid) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: got rsp_data %h with nothing expected", rsp_data);
                end else begin
                    cur = sbq[0];
                    if (!mon_prev) check("rsp_latency", cyc - cur.hs, cur.lat);
                    check("rsp_data", rsp_data, cur.d);
                    check("rsp_err", rsp_err, cur.e);
                    check("req_ready_in_resp", req_ready, 1'b0);
                    if (rsp_ready) void'(sbq.pop_front());
                end
            end
            mon_prev = rsp_valid && !rsp_ready && !rst;
        end
    end

    // ---------------------------------------------------------------- driver
    // Issue one request and push its expected response at the handshake edge.
    // With hold=1, REQ_VALID stays high so that the next request follows
    // immediately.
    task automatic send(input logic we, input logic [11:0] a, input logic [15:0] d,
                        input logic [15:0] ed, input logic ee, input int lat,
                        input logic hold);
        int n;
        n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_data = d;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL handshake_timeout: addr %h never accepted", a);
                req_valid = 1'b0;
                return;
            end
        end
        sbq.push_back('{ed, ee, cyc + 1, lat});
        last_hs = cyc + 1;
        $display("req  we=%0b addr=%h data=%h handshake edge %0d", we, a, d, cyc + 1);
        if (!hold) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 60) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: %0d responses outstanding", sbq.size());
                sbq.delete();
            end
        end
    endtask

    task automatic preload(input logic which3, input logic [11:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_addr = a; pre_data = d;
        if (which3) pre3_we = 1'b1; else pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0; pre3_we = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : stim
        int hs1, hs2, rel_edge, n, rcount, first_v;
        logic [15:0] d3;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
        rsp_ready = 1'b1;
        r3_valid = 1'b0; r3_we = 1'b0; r3_addr = '0; r3_data = '0; s3_ready = 1'b1;
        pre_we = 1'b0; pre3_we = 1'b0; pre_addr = '0; pre_data = '0;

        preload(1'b0, 12'h0FF, 16'h7777);
        preload(1'b0, 12'h100, 16'h6666);
        preload(1'b1, 12'hFFF, 16'h1234);

        @(negedge clk);
        check("reset_ctrl_outputs", {req_ready, rsp_valid, rsp_err, ram_e, ram_w, ram_r}, 6'b0);
        check("reset_rsp_data", rsp_data, 16'h0000);
        check("reset_ram_addr_d", {ram_addr, ram_d}, 28'h0);

        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("ready_after_reset", req_ready, 1'b1);

        // Write followed by a read of the same word.
        send(1'b1, 12'h3A5, 16'hBEEF, 16'hBEEF, 1'b0, 1, 1'b0);
        send(1'b0, 12'h3A5, 16'h0000, 16'hBEEF, 1'b0, 1, 1'b0);
        drain();

        // Back-to-back requests with REQ_VALID held high: spacing must be 3 cycles.
        send(1'b1, 12'h123, 16'h0F0F, 16'h0F0F, 1'b0, 1, 1'b1);
        hs1 = last_hs;
        send(1'b0, 12'h123, 16'h0000, 16'h0F0F, 1'b0, 1, 1'b0);
        check("min_spacing", last_hs - hs1, 3);
        drain();

        // Stall in RESP for 5 cycles while a second request waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(1'b1, 12'h222, 16'h2222, 16'h2222, 1'b0, 1, 1'b1);
        rel_edge = 0;
        fork
            send(1'b0, 12'h222, 16'h0000, 16'h2222, 1'b0, 1, 1'b0);
            begin
                n = 0;
                while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
                repeat (4) @(negedge clk);
                @(posedge clk); #1;
                rsp_ready = 1'b1;
                rel_edge = cyc + 1;
            end
        join
        hs2 = last_hs;
        check("accept_after_release", hs2, rel_edge + 1);
        drain();

        // Reset during a write: the old word must survive.
        send(1'b1, 12'h010, 16'hAAAA, 16'hAAAA, 1'b0, 1, 1'b0);
        drain();
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h010; req_data = 16'h5555;
        @(negedge clk);
        check("ready_before_abort", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        check("write_in_progress", {ram_e, ram_w}, 2'b11);
        rst = 1'b1;
        #1;
        check("abort_ctrl_outputs", {req_ready, rsp_valid, rsp_err, ram_e, ram_w, ram_r}, 6'b0);
        check("abort_rsp_data", rsp_data, 16'h0000);
        check("abort_ram_addr_d", {ram_addr, ram_d}, 28'h0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("ready_after_abort", req_ready, 1'b1);
        @(negedge clk);
        check("no_rsp_after_abort", rsp_valid, 1'b0);
        send(1'b0, 12'h010, 16'h0000, 16'hAAAA, 1'b0, 1, 1'b0);
        drain();

        // Write-protect boundary.
`ifdef MEMCTL_WP_EN
        wp_watch = 1'b1;
        w_seen   = 0;
        send(1'b1, 12'h0FF, 16'h0042, 16'h0000, 1'b1, 1, 1'b0);
        drain();
        wp_watch = 1'b0;
        check("wp_ram_w_seen", w_seen, 0);
        send(1'b0, 12'h0FF, 16'h0000, 16'h7777, 1'b0, 1, 1'b0);
        send(1'b1, 12'h100, 16'h0042, 16'h0042, 1'b0, 1, 1'b0);
        send(1'b0, 12'h100, 16'h0000, 16'h0042, 1'b0, 1, 1'b0);
        drain();
`else
        send(1'b1, 12'h0FF, 16'h0042, 16'h0042, 1'b0, 1, 1'b0);
        send(1'b0, 12'h0FF, 16'h0000, 16'h0042, 1'b0, 1, 1'b0);
        send(1'b1, 12'h100, 16'h0042, 16'h0042, 1'b0, 1, 1'b0);
        send(1'b0, 12'h100, 16'h0000, 16'h0042, 1'b0, 1, 1'b0);
        drain();
`endif

        // RD_WAIT=3 read of 0xFFF on the second instance.
        @(posedge clk); #1;
        r3_valid = 1'b1; r3_we = 1'b0; r3_addr = 12'hFFF;
        n = 0;
        forever begin
            @(negedge clk);
            if (r3_ready || n > 50) break;
            n++;
        end
        check("rd3_accepted", r3_ready, 1'b1);
        hs1 = cyc + 1;
        @(posedge clk); #1;
        r3_valid = 1'b0;
        rcount  = 0;
        first_v = -1;
        d3      = 16'h0000;
        repeat (12) begin
            @(negedge clk);
            if (ram3_r) rcount++;
            if (s3_valid && first_v < 0) begin
                first_v = cyc;
                d3 = s3_data;
            end
        end
        check("rd3_ram_r_cycles", rcount, 4);
        check("rd3_latency", first_v - hs1, 4);
        check("rd3_data", d3, 16'h1234);
        check("rd3_ram_w_idle", {ram3_w, ram3_e}, 2'b00);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
